// File: rtl/bsg_manycore_pod_row_reset_sequencer_pkg.sv
// Shared types and defaults for the pod-row reset sequencer.
package bsg_manycore_pkg;

  typedef enum logic [1:0] {HOLD, GAP, IDLE, FIN} bsg_pod_rst_seq_state_e;

  localparam int pod_rst_hold_cycles_default = 16;
  localparam int pod_rst_gap_cycles_default  = 8;

  // clog2 that never returns 0, so single-entry widths stay legal
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_manycore_pod_row_reset_sequencer_if.sv
// Request/status bundle between a re-reset client and the pod-row reset sequencer.
interface bsg_manycore_pod_row_reset_sequencer_if #(
  parameter int num_pods_x_p  = 1,
  parameter int num_tiles_x_p = 1
);
  logic                                         v_i;
  logic [num_pods_x_p-1:0]                      pod_mask_i;
  logic                                         ready_o;
  logic [num_pods_x_p-1:0][num_tiles_x_p-1:0]   reset_o;
  logic                                         busy_o;
  logic                                         done_o;

  modport master (output v_i, pod_mask_i, input ready_o, reset_o, busy_o, done_o);
  modport slave  (input v_i, pod_mask_i, output ready_o, reset_o, busy_o, done_o);
endinterface

// File: rtl/bsg_manycore_pod_row_reset_sequencer_priority_encode.sv
// Priority encoder: index of the first set bit, scanning from bit 0 when lo_to_hi_p.
module bsg_priority_encode
  import bsg_manycore_pkg::*;
#(
  parameter int width_p    = 1,
  parameter bit lo_to_hi_p = 1'b1
)(
  input  logic [width_p-1:0]                 i,
  output logic [safe_clog2(width_p)-1:0]     addr_o,
  output logic                               v_o
);

  localparam int addr_w = safe_clog2(width_p);

  always_comb begin
    addr_o = '0;
    v_o    = |i;
    if (lo_to_hi_p) begin
      // scan downward so the lowest set bit is written last and wins
      for (int k = width_p-1; k >= 0; k--)
        if (i[k]) addr_o = addr_w'(k);
    end else begin
      for (int k = 0; k < width_p; k++)
        if (i[k]) addr_o = addr_w'(k);
    end
  end

endmodule

// File: rtl/bsg_manycore_pod_row_reset_sequencer.sv
// Staggered per-pod reset release for a row of manycore pods, with re-reset requests.
module bsg_manycore_pod_row_reset_sequencer
  import bsg_manycore_pkg::*;
#(
  parameter int num_pods_x_p  = 1,
  parameter int num_tiles_x_p = 1,
  parameter int hold_cycles_p = pod_rst_hold_cycles_default,
  parameter int gap_cycles_p  = pod_rst_gap_cycles_default
)(
  input  logic clk_i,
  input  logic reset_i,
  bsg_manycore_pod_row_reset_sequencer_if.slave seq_if
);

  localparam int cnt_w = safe_clog2(((hold_cycles_p > gap_cycles_p) ? hold_cycles_p : gap_cycles_p) + 1);
  localparam int pod_w = safe_clog2(num_pods_x_p);
  localparam logic [cnt_w-1:0] hold_last = cnt_w'(hold_cycles_p - 1);
  localparam logic [cnt_w-1:0] gap_last  = cnt_w'(gap_cycles_p - 1);

  bsg_pod_rst_seq_state_e  state_r;
  logic [cnt_w-1:0]        cnt_r;
  logic [num_pods_x_p-1:0] rem_r;
  logic [num_pods_x_p-1:0] pod_rst_r;
  logic                    ready_r, busy_r, done_r;
  logic                    boot_r;

  logic [pod_w-1:0]        next_pod;
  logic                    next_v;
  logic [num_pods_x_p-1:0] next_oh, rem_after;
  logic                    last, advance;

  bsg_priority_encode #(.width_p(num_pods_x_p), .lo_to_hi_p(1'b1)) pe (
    .i      (rem_r),
    .addr_o (next_pod),
    .v_o    (next_v)
  );

  assign next_oh   = num_pods_x_p'(1) << next_pod;
  assign rem_after = rem_r & ~next_oh;
  assign last      = ~|rem_after;

  // The first edge out of reset plays the role of an all-ones acceptance,
  // so HOLD does not count on that edge (boot_r).
  assign advance = ((state_r == HOLD) && !boot_r && (cnt_r == hold_last))
                || ((state_r == GAP)  && (cnt_r == gap_last));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r   <= HOLD;
      cnt_r     <= '0;
      rem_r     <= '1;
      pod_rst_r <= '1;
      ready_r   <= 1'b0;
      busy_r    <= 1'b1;
      done_r    <= 1'b0;
      boot_r    <= 1'b1;
    end else begin
      done_r <= 1'b0;
      boot_r <= 1'b0;
      case (state_r)
        HOLD, GAP: begin
          if (advance) begin
            cnt_r <= '0;
            if (next_v) begin
              pod_rst_r <= pod_rst_r & ~next_oh;
              rem_r     <= rem_after;
              if (last) begin
                state_r <= IDLE;
                done_r  <= 1'b1;
                busy_r  <= 1'b0;
              end else begin
                state_r <= GAP;
              end
            end else begin
              state_r <= FIN;
              done_r  <= 1'b1;
            end
          end else if (!boot_r) begin
            cnt_r <= cnt_r + cnt_w'(1);
          end
        end
        IDLE: begin
          if (seq_if.v_i && ready_r) begin
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            cnt_r   <= '0;
            if (seq_if.pod_mask_i == '0) begin
              state_r <= FIN;
              done_r  <= 1'b1;
            end else begin
              state_r   <= HOLD;
              rem_r     <= seq_if.pod_mask_i;
              pod_rst_r <= pod_rst_r | seq_if.pod_mask_i;
            end
          end else begin
            ready_r <= 1'b1;
          end
        end
        FIN: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < num_pods_x_p; p++) begin : g_pod
    assign seq_if.reset_o[p] = {num_tiles_x_p{pod_rst_r[p]}};
  end

  assign seq_if.ready_o = ready_r;
  assign seq_if.busy_o  = busy_r;
  assign seq_if.done_o  = done_r;

endmodule

// File: tb/tb_bsg_manycore_pod_row_reset_sequencer.sv
// Directed-vector bench: 3-pod row (hold 4, gap 2) plus a 1-pod instance (hold 1, gap 1).
module tb_bsg_manycore_pod_row_reset_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst1 = 1'b1;
  always #5 clk = ~clk;

  bsg_manycore_pod_row_reset_sequencer_if #(.num_pods_x_p(3), .num_tiles_x_p(4)) sif ();
  bsg_manycore_pod_row_reset_sequencer_if #(.num_pods_x_p(1), .num_tiles_x_p(1)) sif1 ();

  bsg_manycore_pod_row_reset_sequencer #(
    .num_pods_x_p(3), .num_tiles_x_p(4), .hold_cycles_p(4), .gap_cycles_p(2)
  ) dut (
    .clk_i(clk), .reset_i(rst), .seq_if(sif)
  );

  bsg_manycore_pod_row_reset_sequencer #(
    .num_pods_x_p(1), .num_tiles_x_p(1), .hold_cycles_p(1), .gap_cycles_p(1)
  ) dut1 (
    .clk_i(clk), .reset_i(rst1), .seq_if(sif1)
  );

  // edges since reset release; at a negedge, ecount == n means "cycle n"
  int ecount, ecount1;
  int nvec = 0;
  int nerr = 0;

  always @(posedge clk or posedge rst)
    if (rst) ecount <= 0; else ecount <= ecount + 1;
  always @(posedge clk or posedge rst1)
    if (rst1) ecount1 <= 0; else ecount1 <= ecount1 + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rv(input logic p2, input logic p1, input logic p0);
    return 32'({{4{p2}}, {4{p1}}, {4{p0}}});
  endfunction

  task automatic goto(input int n);
    while (ecount < n) @(negedge clk);
  endtask

  task automatic goto1(input int n);
    while (ecount1 < n) @(negedge clk);
  endtask

  task automatic check_powerup(input string pfx);
    for (int n = 0; n <= 10; n++) begin
      goto(n);
      chk($sformatf("%s_rst@%0d", pfx, n), 32'(sif.reset_o), rv(n < 9, n < 7, n < 5));
      chk($sformatf("%s_done@%0d", pfx, n), 32'(sif.done_o), 32'(n == 9));
      chk($sformatf("%s_ready@%0d", pfx, n), 32'(sif.ready_o), 32'(n >= 10));
      chk($sformatf("%s_busy@%0d", pfx, n), 32'(sif.busy_o), 32'(n < 9));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sif.v_i = 1'b0;  sif.pod_mask_i = 3'b000;
    sif1.v_i = 1'b0; sif1.pod_mask_i = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_state_reset", 32'(sif.reset_o), 32'hfff);
    chk("rst_state_ready", 32'(sif.ready_o), 32'd0);
    chk("rst_state_busy",  32'(sif.busy_o),  32'd1);
    chk("rst_state_done",  32'(sif.done_o),  32'd0);

    // power-up staggered release
    rst = 1'b0;
    check_powerup("pu");

    // mask 101 accepted at 20, mask 010 held from 22 and accepted at 28
    for (int n = 20; n <= 34; n++) begin
      goto(n);
      case (n)
        20: begin sif.v_i = 1'b1; sif.pod_mask_i = 3'b101; end
        21: sif.v_i = 1'b0;
        22: begin sif.v_i = 1'b1; sif.pod_mask_i = 3'b010; end
        29: sif.v_i = 1'b0;
        default: ;
      endcase
      chk($sformatf("rr_rst@%0d", n), 32'(sif.reset_o),
          rv(n >= 21 && n < 27, n >= 29 && n < 33, n >= 21 && n < 25));
      chk($sformatf("rr_done@%0d", n), 32'(sif.done_o), 32'(n == 27 || n == 33));
      chk($sformatf("rr_ready@%0d", n), 32'(sif.ready_o), 32'(n == 20 || n == 28 || n == 34));
    end

    // empty mask accepted at 40
    goto(40);
    chk("m0_ready@40", 32'(sif.ready_o), 32'd1);
    sif.v_i = 1'b1; sif.pod_mask_i = 3'b000;
    goto(41);
    sif.v_i = 1'b0;
    chk("m0_done@41",  32'(sif.done_o),  32'd1);
    chk("m0_ready@41", 32'(sif.ready_o), 32'd0);
    chk("m0_rst@41",   32'(sif.reset_o), 32'd0);
    goto(42);
    chk("m0_done@42",  32'(sif.done_o),  32'd0);
    chk("m0_ready@42", 32'(sif.ready_o), 32'd1);
    chk("m0_rst@42",   32'(sif.reset_o), 32'd0);

    // asynchronous reset in the middle of power-up, then full restart
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    goto(6);
    chk("ar_pre_rst@6", 32'(sif.reset_o), rv(1'b1, 1'b1, 1'b0));
    #2 rst = 1'b1;
    #1;
    chk("ar_async_rst",   32'(sif.reset_o), 32'hfff);
    chk("ar_async_ready", 32'(sif.ready_o), 32'd0);
    chk("ar_async_busy",  32'(sif.busy_o),  32'd1);
    @(negedge clk) rst = 1'b0;
    check_powerup("ar");

    // single pod, hold 1, gap 1
    chk("p1_reset_state", 32'(sif1.reset_o), 32'd1);
    chk("p1_reset_ready", 32'(sif1.ready_o), 32'd0);
    rst1 = 1'b0;
    for (int n = 0; n <= 8; n++) begin
      goto1(n);
      if (n == 5) begin sif1.v_i = 1'b1; sif1.pod_mask_i = 1'b1; end
      if (n == 6) sif1.v_i = 1'b0;
      chk($sformatf("p1_rst@%0d", n),   32'(sif1.reset_o), 32'(n < 2 || n == 6));
      chk($sformatf("p1_done@%0d", n),  32'(sif1.done_o),  32'(n == 2 || n == 7));
      chk($sformatf("p1_ready@%0d", n), 32'(sif1.ready_o), 32'(n >= 3 && n <= 5 || n == 8));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_pod_row_reset_sequencer.md
Name: bsg_manycore_pod_row_reset_sequencer

Overview:
Generates the per-pod, per-tile reset vector for a row of manycore pods. Supported operations:
- Staggers reset release pod-by-pod, limiting di/dt and simultaneous icache/vcache init traffic.
- After power-up, accepts software-style re-reset requests for any subset of pods.
Sits beside the pod mesh row. Its reset_o drives the row's per-pod/per-tile reset input directly.

Parameters:
num_pods_x_p, (required), number of pods in the row; >=1
num_tiles_x_p, (required), tile columns per pod; each pod's tiles share one reset value
hold_cycles_p, 16, cycles reset is held asserted before the first release; >=1
gap_cycles_p, 8, cycles between consecutive pod releases; >=1

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
v_i  in  1  re-reset request valid
pod_mask_i  in  num_pods_x_p  pods to re-reset; bit x = pod x
ready_o  out  1  request can be accepted; handshake = v_i & ready_o
reset_o  out  num_pods_x_p*num_tiles_x_p  [pod][tile] reset; 1 = in reset
busy_o  out  1  sequence in progress
done_o  out  1  one-cycle pulse when a sequence completes

Behaviour:
- All outputs come from flops. reset_i clears them asynchronously to:
  - reset_o = all 1s
  - ready_o = 0, busy_o = 1, done_o = 0
  - state = HOLD, active mask = all 1s, counter = 0
- reset_o[x][*] is always replicated across tiles; it never differs within a pod.
- States:
  - HOLD: counts hold_cycles_p cycles, then releases the lowest set mask bit and moves to GAP. If no bits remain, go to FIN.
  - GAP: counts gap_cycles_p cycles, then releases the next set mask bit in ascending index order. Clear pods are skipped at zero cycle cost (priority encode). The cycle that releases the last set bit goes directly to IDLE and pulses done_o.
  - IDLE: ready_o = 1, busy_o = 0.
  - FIN: pulses done_o, then goes to IDLE.
- Power-up: the first clock edge after reset_i deasserts is cycle 0. It acts as acceptance of mask all-ones.
- Request accepted at edge T:
  - At T+1, reset_o = 1 for masked pods; other pods are untouched.
  - Masked pods stay in reset through T+hold_cycles_p.
  - First masked pod releases at T+hold_cycles_p+1.
  - Each next masked pod releases gap_cycles_p cycles later.
  - done_o pulses in the cycle of the final release.
  - ready_o rises the following cycle.
- Mask = 0: accepted. No reset_o change. State goes to FIN; done_o pulses at T+1 and ready_o returns at T+2.
- Request while busy: ready_o = 0. The request is not latched and the caller must hold v_i.
- Pods that are not masked keep their reset_o value for the whole sequence.
- Counter width is clog2(max(hold_cycles_p, gap_cycles_p)+1). The counter resets to 0 on each state entry and never wraps.
- reset_i asserted mid-sequence: all pods return to reset immediately, without waiting for a clock. The full power-up sequence restarts after deassertion. Any in-flight request is dropped.
- Async reset is deasserted into the block synchronously. Synchronization is the integrator's responsibility; the block does not synchronize reset_i.

Decomposition:
- Shared package (bsg_manycore_pkg):
  - the state enum {HOLD, GAP, IDLE, FIN} as bsg_pod_rst_seq_state_e
  - default hold/gap constants
- Sub-module: bsg_priority_encode (basejump), used for next-pod selection over the remaining-mask register.
- Release of a pod clears its bit in the remaining mask.

Test Plan:
(num_pods_x_p=3, num_tiles_x_p=4, hold=4, gap=2 unless stated.)
1. Power-up: deassert reset_i before edge 0. All reset_o = 1 through cycle 4. Pod0 releases at 5, pod1 at 7, pod2 at 9. done_o = 1 only at 9. ready_o = 1 at 10.
2. Mask 3'b101 accepted at T=20:
   - reset_o[0] and reset_o[2] = 1 during cycles 21..24.
   - Pod0 released at 25, pod2 at 27; done_o at 27.
   - reset_o[1] stays 0 throughout.
3. Mask 3'b000 accepted at T=40: reset_o unchanged. done_o at 41, ready_o = 0 at 41, ready_o = 1 at 42.
4. v_i held with mask 3'b010 from cycle 22 during test 2's sequence:
   - Not accepted until cycle 28, when ready_o = 1.
   - Pod1 in reset 29..32, released at 33.
5. Assert reset_i asynchronously at cycle 6 of power-up (pod0 already released): reset_o goes all 1s before the next edge. Full sequence timing of test 1 repeats after deassertion.
6. num_pods_x_p=1, hold=1, gap=1: pod0 releases at cycle 2, done_o at 2. Mask 1'b1 at T → pod0 in reset at T+1, released at T+2.
